// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller and MDU sequencer for the five-stage MIPS pipeline.
// Optional stall statistics (STALL_COUNT, BUBBLE_LD) are built when HAZ_STATS_EN is defined.
module phc_fwd_lane (
  input  logic       uses,
  input  logic [4:0] src,
  input  logic       ex_fwd_ok,
  input  logic [4:0] ex_reg,
  input  logic       mem_rf,
  input  logic [4:0] mem_reg,
  input  logic       wb_rf,
  input  logic [4:0] wb_reg,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (uses && src != 5'd0) begin
      if (ex_fwd_ok && ex_reg == src)      sel = 2'b01;
      else if (mem_rf && mem_reg == src)   sel = 2'b10;
      else if (wb_rf && wb_reg == src)     sel = 2'b11;
    end
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RS,
  input  logic        ID_USES_RT,
  input  logic        ID_MDU_START,
  input  logic        ID_MDU_DIV,
  input  logic        ID_READS_HILO,
  input  logic        EX_LOAD_INSTR,
  input  logic        EX_RF_ENABLE,
  input  logic [4:0]  EX_REG,
  input  logic        MEM_RF_ENABLE,
  input  logic [4:0]  MEM_REG,
  input  logic        WB_RF_ENABLE,
  input  logic [4:0]  WB_REG,
  output logic        PC_LE,
  output logic        IF_ID_LE,
  output logic        ID_EX_BUBBLE,
  output logic [1:0]  MX1_SEL,
  output logic [1:0]  MX2_SEL,
  output logic        MDU_BUSY,
  output logic        MDU_DONE,
`ifdef HAZ_STATS_EN
  output logic [31:0] STALL_COUNT,
  output logic [31:0] BUBBLE_LD,
`endif
  output logic        STATE
);
  localparam int NUM_LANES = 2;
  localparam logic [7:0] MUL_LD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LD = 8'(DIV_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

  state_t state, state_nxt, st_eff;
  logic [7:0] cnt, cnt_nxt;
  logic ld_stall, mdu_stall, stall;

  logic [NUM_LANES-1:0]       uses;
  logic [NUM_LANES-1:0][4:0]  src;
  logic [NUM_LANES-1:0][1:0]  sel;

  assign uses = {ID_USES_RT, ID_USES_RS};
  assign src  = {ID_RT, ID_RS};

  // A load still in EX has no data yet; its consumers get a stall instead.
  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      phc_fwd_lane u_lane (
        .uses      (uses[l]),
        .src       (src[l]),
        .ex_fwd_ok (EX_RF_ENABLE && !EX_LOAD_INSTR),
        .ex_reg    (EX_REG),
        .mem_rf    (MEM_RF_ENABLE),
        .mem_reg   (MEM_REG),
        .wb_rf     (WB_RF_ENABLE),
        .wb_reg    (WB_REG),
        .sel       (sel[l])
      );
    end
  endgenerate

  assign MX1_SEL = sel[0];
  assign MX2_SEL = sel[1];

  // While reset is held the controller behaves as if already in RUN.
  assign st_eff = Reset ? state : RUN;

  assign ld_stall  = EX_LOAD_INSTR && EX_RF_ENABLE && (EX_REG != 5'd0) &&
                     ((ID_USES_RS && ID_RS == EX_REG) || (ID_USES_RT && ID_RT == EX_REG));
  assign mdu_stall = (st_eff == MDU_WAIT) && (ID_MDU_START || ID_READS_HILO);
  assign stall     = ld_stall || mdu_stall;

  assign PC_LE        = !stall;
  assign IF_ID_LE     = !stall;
  assign ID_EX_BUBBLE = stall;
  assign STATE        = st_eff;

  always_comb begin
    state_nxt = st_eff;
    cnt_nxt   = cnt;
    MDU_BUSY  = 1'b0;
    MDU_DONE  = 1'b0;
    case (st_eff)
      RUN: begin
        if (ID_MDU_START && !ld_stall) begin
          state_nxt = MDU_WAIT;
          cnt_nxt   = ID_MDU_DIV ? DIV_LD : MUL_LD;
        end
      end
      MDU_WAIT: begin
        MDU_BUSY = 1'b1;
        if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
        else begin
          MDU_DONE  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      STALL_COUNT <= 32'd0;
      BUBBLE_LD   <= 32'd0;
    end else begin
      if (stall && STALL_COUNT != 32'hFFFF_FFFF)  STALL_COUNT <= STALL_COUNT + 32'd1;
      if (ld_stall && BUBBLE_LD != 32'hFFFF_FFFF) BUBBLE_LD   <= BUBBLE_LD + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default MULT/DIV cycle counts).
module tb_pipeline_hazard_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  logic [4:0] ID_RS, ID_RT, EX_REG, MEM_REG, WB_REG;
  logic ID_USES_RS, ID_USES_RT, ID_MDU_START, ID_MDU_DIV, ID_READS_HILO;
  logic EX_LOAD_INSTR, EX_RF_ENABLE, MEM_RF_ENABLE, WB_RF_ENABLE;
  logic PC_LE, IF_ID_LE, ID_EX_BUBBLE, MDU_BUSY, MDU_DONE, STATE;
  logic [1:0] MX1_SEL, MX2_SEL;
`ifdef HAZ_STATS_EN
  logic [31:0] STALL_COUNT, BUBBLE_LD;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT),
    .ID_MDU_START(ID_MDU_START), .ID_MDU_DIV(ID_MDU_DIV), .ID_READS_HILO(ID_READS_HILO),
    .EX_LOAD_INSTR(EX_LOAD_INSTR), .EX_RF_ENABLE(EX_RF_ENABLE), .EX_REG(EX_REG),
    .MEM_RF_ENABLE(MEM_RF_ENABLE), .MEM_REG(MEM_REG),
    .WB_RF_ENABLE(WB_RF_ENABLE), .WB_REG(WB_REG),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .ID_EX_BUBBLE(ID_EX_BUBBLE),
    .MX1_SEL(MX1_SEL), .MX2_SEL(MX2_SEL),
    .MDU_BUSY(MDU_BUSY), .MDU_DONE(MDU_DONE),
`ifdef HAZ_STATS_EN
    .STALL_COUNT(STALL_COUNT), .BUBBLE_LD(BUBBLE_LD),
`endif
    .STATE(STATE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave time to drive inputs before sampling.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    ID_RS = 0; ID_RT = 0; ID_USES_RS = 0; ID_USES_RT = 0;
    ID_MDU_START = 0; ID_MDU_DIV = 0; ID_READS_HILO = 0;
    EX_LOAD_INSTR = 0; EX_RF_ENABLE = 0; EX_REG = 0;
    MEM_RF_ENABLE = 0; MEM_REG = 0; WB_RF_ENABLE = 0; WB_REG = 0;
  endtask

  task automatic chk_stall(input string tag, input logic s);
    chk({tag, ".pc_le"}, PC_LE, !s);
    chk({tag, ".ifid_le"}, IF_ID_LE, !s);
    chk({tag, ".bubble"}, ID_EX_BUBBLE, s);
  endtask

  initial begin
    int busy_n, done_n, done_at, stall_n;
    clr();
    Reset = 0;
    step(); step();
    #1;
    chk("rst.state", STATE, 0);
    chk("rst.busy", MDU_BUSY, 0);
    chk("rst.done", MDU_DONE, 0);
    chk_stall("rst", 0);
    Reset = 1;

    // Forwarding priority and zero register
    step();
    EX_REG = 5; EX_RF_ENABLE = 1; MEM_REG = 5; MEM_RF_ENABLE = 1; ID_RS = 5; ID_USES_RS = 1;
    #1 chk("fwd.ex", MX1_SEL, 2'b01);
    EX_RF_ENABLE = 0;
    #1 chk("fwd.mem", MX1_SEL, 2'b10);
    WB_REG = 5; WB_RF_ENABLE = 1; MEM_RF_ENABLE = 0;
    #1 chk("fwd.wb", MX1_SEL, 2'b11);
    ID_RS = 0; WB_REG = 0;
    #1 chk("fwd.r0", MX1_SEL, 2'b00);
    ID_RS = 5; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1; MEM_RF_ENABLE = 1;
    #1 chk("fwd.ld_skip_ex", MX1_SEL, 2'b10);
    chk_stall("fwd.ld", 1);
    clr();
    ID_RT = 7; ID_USES_RT = 1; WB_REG = 7; WB_RF_ENABLE = 1;
    #1 chk("fwd.rt_wb", MX2_SEL, 2'b11);
    chk("fwd.rs_idle", MX1_SEL, 2'b00);
    ID_USES_RT = 0;
    #1 chk("fwd.rt_unused", MX2_SEL, 2'b00);

    // Load-use: one stall cycle, then forwarded from MEM
    clr();
    EX_LOAD_INSTR = 1; EX_RF_ENABLE = 1; EX_REG = 8; ID_RT = 8; ID_USES_RT = 1;
    #1 chk_stall("lu.stall", 1);
    step();
    EX_LOAD_INSTR = 0; EX_RF_ENABLE = 0; EX_REG = 0; MEM_REG = 8; MEM_RF_ENABLE = 1;
    #1 chk("lu.mx2", MX2_SEL, 2'b10);
    chk_stall("lu.after", 0);
    clr();
    EX_LOAD_INSTR = 1; EX_RF_ENABLE = 1; EX_REG = 0; ID_RT = 0; ID_USES_RT = 1;
    #1 chk_stall("lu.r0", 0);

    // Multiply with an mfhi waiting in ID
    clr();
    ID_MDU_START = 1;
    #1 chk_stall("mul.accept", 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      ID_MDU_START = 0; ID_READS_HILO = 1;
      #1;
      chk($sformatf("mul.busy%0d", i), MDU_BUSY, 1);
      chk($sformatf("mul.done%0d", i), MDU_DONE, (i == 4));
      chk($sformatf("mul.state%0d", i), STATE, 1);
      chk($sformatf("mul.pcle%0d", i), PC_LE, 0);
    end
    step();
    #1;
    chk("mul.n5.busy", MDU_BUSY, 0);
    chk("mul.n5.state", STATE, 0);
    chk_stall("mul.n5", 0);
    ID_READS_HILO = 0;

    // Divide then multiply back-to-back, with an independent add mid-divide
    ID_MDU_START = 1; ID_MDU_DIV = 1;
    busy_n = 0; done_n = 0; done_at = 0; stall_n = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      ID_MDU_DIV = 0;
      if (i == 10) begin
        ID_MDU_START = 0; ID_RS = 3; ID_USES_RS = 1;
        #1 chk_stall("div.add", 0);
        ID_MDU_START = 1; ID_USES_RS = 0;
      end
      #1;
      busy_n += MDU_BUSY;
      stall_n += ID_EX_BUBBLE;
      if (MDU_DONE) begin done_n++; done_at = i; end
    end
    chk("div.busy_cnt", busy_n, 32);
    chk("div.done_cnt", done_n, 1);
    chk("div.done_at", done_at, 32);
    chk("div.stall_cnt", stall_n, 32);
    step();
    #1;
    chk("b2b.gap.state", STATE, 0);
    chk("b2b.gap.busy", MDU_BUSY, 0);
    chk_stall("b2b.gap", 0);
    busy_n = 0; done_at = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      ID_MDU_START = 0;
      #1;
      busy_n += MDU_BUSY;
      if (MDU_DONE) done_at = i;
    end
    chk("b2b.mul.busy_cnt", busy_n, 4);
    chk("b2b.mul.done_at", done_at, 4);

    // Reset in the middle of a divide
    clr();
    ID_MDU_START = 1; ID_MDU_DIV = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      ID_MDU_START = 0; ID_MDU_DIV = 0;
    end
    #1 chk("rstm.busy_pre", MDU_BUSY, 1);
    Reset = 0;
    step();
    Reset = 1;
    #1;
    chk("rstm.state", STATE, 0);
    chk("rstm.busy", MDU_BUSY, 0);
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      done_n += MDU_DONE;
    end
    chk("rstm.no_done", done_n, 0);

`ifdef HAZ_STATS_EN
    chk("stat.rst_stall", STALL_COUNT, 0);
    chk("stat.rst_ld", BUBBLE_LD, 0);
    for (int k = 0; k < 3; k++) begin
      clr();
      EX_LOAD_INSTR = 1; EX_RF_ENABLE = 1; EX_REG = 9; ID_RS = 9; ID_USES_RS = 1;
      step();
      clr();
      step();
    end
    ID_MDU_START = 1;
    step();
    ID_MDU_START = 0; ID_READS_HILO = 1;
    for (int k = 0; k < 5; k++) step();
    ID_READS_HILO = 0;
    step();
    chk("stat.stall", STALL_COUNT, 7);
    chk("stat.ld", BUBBLE_LD, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. It drives the load enables of the PC and IF/ID register, inserts bubbles into ID/EX, and generates the operand-forwarding selects for the ID-stage MX1/MX2 muxes. It also runs the multi-cycle multiply/divide (MDU) sequencer that owns the HI/LO write. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and observes their destination-register and control outputs.

## Interface
Clock is one rising-edge `Clk`. `Reset` is synchronous and active-low: 0 resets on the next rising edge of `Clk`.

Parameters:
- MULT_CYCLES, 4, MDU busy cycles for mult/multu (legal range 1..255)
- DIV_CYCLES, 32, MDU busy cycles for div/divu (legal range 1..255)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous active-low reset
- ID_RS, ID_RT  in  5 each  source registers of the instruction in ID
- ID_USES_RS, ID_USES_RT  in  1 each  the ID instruction reads that source
- ID_MDU_START  in  1  the ID instruction is mult/multu/div/divu
- ID_MDU_DIV  in  1  1 = divide, 0 = multiply (qualified by ID_MDU_START)
- ID_READS_HILO  in  1  the ID instruction is mfhi/mflo
- EX_LOAD_INSTR, EX_RF_ENABLE  in  1 each  ID/EX control outputs
- EX_REG  in  5  ID/EX destination register
- MEM_RF_ENABLE  in  1, MEM_REG  in  5  EX/MEM writeback info
- WB_RF_ENABLE  in  1, WB_REG  in  5  MEM/WB writeback info
- PC_LE  out  1  PC load enable
- IF_ID_LE  out  1  IF/ID load enable
- ID_EX_BUBBLE  out  1  force all ID/EX control inputs to 0
- MX1_SEL, MX2_SEL  out  2 each  rs/rt operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
- MDU_BUSY  out  1  MDU sequencer active
- MDU_DONE  out  1  one-cycle pulse; HI/LO write enable
- STATE  out  1  0 = RUN, 1 = MDU_WAIT

## Operation
- Forwarding is combinational and applies to each of rs and rt independently.
  - A source matches a stage when its USES bit is 1, the stage's RF_ENABLE is 1, the stage register equals the source, and the source is non-zero.
  - EX matches only when EX_LOAD_INSTR is 0.
  - Priority is EX > MEM > WB. With no match the select is 00.
- Load-use stall (`ld_stall`) is raised when EX_LOAD_INSTR, EX_RF_ENABLE and EX_REG≠0 are all true and either used source equals EX_REG.
- MDU stall (`mdu_stall`) is raised when the state is MDU_WAIT and ID_MDU_START or ID_READS_HILO is 1.
- When `stall` = `ld_stall` | `mdu_stall`: PC_LE=0, IF_ID_LE=0, ID_EX_BUBBLE=1. Otherwise PC_LE=1, IF_ID_LE=1, ID_EX_BUBBLE=0.
- The FSM has two states, RUN and MDU_WAIT, with an 8-bit down-counter `cnt`.
  - RUN → MDU_WAIT when ID_MDU_START is 1 and `ld_stall` is 0. On that edge `cnt` loads (ID_MDU_DIV ? DIV_CYCLES : MULT_CYCLES) − 1.
  - MDU_WAIT: MDU_BUSY=1. If `cnt`≠0, `cnt` decrements. If `cnt`=0, MDU_DONE=1 and the next state is RUN.
- A new MDU op arriving in the MDU_DONE cycle is stalled in that cycle and accepted on the following RUN cycle. Back-to-back ops therefore have exactly one RUN cycle between them.
- Instructions that touch neither the MDU nor HI/LO flow freely during MDU_WAIT.

## Timing
- Reset values: STATE=RUN, `cnt`=0, MDU_BUSY=0, MDU_DONE=0.
- During reset, combinational outputs still follow their equations using STATE=RUN.
- Forward selects and stall outputs are combinational, with zero-cycle latency from their inputs.
- Op accepted at edge N:
  - MDU_BUSY is high for cycles N+1 .. N+C, where C is the selected cycle count.
  - MDU_DONE is high only in cycle N+C.
  - STATE returns to RUN at edge N+C.
- A load-use stall lasts exactly one cycle, because the load advances to MEM and is then forwarded from MEM.
- Reset asserted mid-MDU: the next edge forces RUN and `cnt`=0, and no MDU_DONE is emitted.

## Configuration
- `HAZ_STATS_EN` defined: adds output STALL_COUNT (32 bits), reset to 0, which increments on every edge where `stall`=1 and saturates at 0xFFFFFFFF. It also adds output BUBBLE_LD (32 bits), counting `ld_stall` cycles only.
- `HAZ_STATS_EN` undefined: neither port nor any counter logic exists.

## Test plan
- Forwarding: EX_REG=5, EX_RF_ENABLE=1, MEM_REG=5, MEM_RF_ENABLE=1, ID_RS=5, ID_USES_RS=1 → MX1_SEL=01. Clear EX_RF_ENABLE → MX1_SEL=10. Set ID_RS=0 → MX1_SEL=00.
- Load-use: EX_LOAD_INSTR=1, EX_REG=8, ID_RT=8, ID_USES_RT=1 → one cycle of PC_LE=0, IF_ID_LE=0, ID_EX_BUBBLE=1. Next cycle with MEM_REG=8 → MX2_SEL=10 and no stall.
- Multiply: ID_MDU_START=1, ID_MDU_DIV=0 at edge N (defaults) → MDU_BUSY high for cycles N+1..N+4, MDU_DONE only in N+4. An mfhi held in ID stalls through N+4 and issues in N+5.
- Divide back-to-back: div then mult presented continuously → 32 busy cycles, then 1 RUN cycle, then 4 busy cycles. The independent add issued during MDU_WAIT sees no stall.
- Reset mid-divide: Reset=0 at busy cycle 10 → after the edge STATE=RUN, MDU_BUSY=0, and MDU_DONE never pulses.
- With `HAZ_STATS_EN`: 3 load-use stalls plus one mult followed by mfhi → STALL_COUNT=7 and BUBBLE_LD=3 (the mfhi stalls for the 4 busy cycles).
